seg7_scan_mux: RTL
==================

# seg7_scan_mux

Time-multiplexed four-digit seven-segment driver sitting directly downstream of the lab top-level datapath: it takes four 5-bit digit codes (hex nibble plus decimal point), double-buffers them, and scans them onto the shared active-low cathodes `a`..`g`, `dp` and anodes `an1`..`an4`. Digit data is captured on a `load` strobe and becomes visible only at a frame boundary, so the display never shows a mix of old and new digits.

## Interface
- `SCAN_DIV`, 16: clock cycles each digit is lit; legal range 2..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `digit0`..`digit3` into the shadow buffer.
- `digit0`..`digit3`  in  5 each  bit4 = decimal point on, bits3:0 = hex value; `digit0` is shown on `an1`, `digit3` on `an4`.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segment cathodes, active-low, registered.
- `dp`  out  1  decimal-point cathode, active-low, registered.
- `an1`..`an4`  out  1 each  digit anodes, active-low, one-hot-low, registered.
- `frame`  out  1  one-cycle pulse on the frame-boundary cycle.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1; terminal count (`pcnt==SCAN_DIV-1`) = scan tick; `pcnt` wraps to 0.
- Digit index `idx` (2 bits) increments on each scan tick, wraps 3→0.
- Frame boundary = scan tick with `idx==3`. On that cycle: active buffer <= (`load` ? digit inputs : shadow); `frame`=1.
- `load` on any cycle writes shadow; `load` coincident with frame boundary writes both shadow and active with the input values.
- Output register each cycle: anode for `idx` low, others high; segments = hex pattern of active[idx][3:0]; `dp` = ~active[idx][4].
- Hex patterns (a..g, active-low) standard: 0=0000001, 1=1001111, 8=0000000, F=0111000.
- States: scan only (no idle state); scanning continues regardless of `load`.
- Reset (asynchronous, any time, including mid-frame): `pcnt`=0, `idx`=0, shadow/active=0, `frame`=0, all anodes=1, all segments=1, `dp`=1. Outputs dark immediately on assertion.

## Timing
- Output registers lag `idx` by one cycle: first cycle after reset release lights `an1` with "0" (a..g=0000001, dp=1) on the following edge.
- Each anode is low exactly SCAN_DIV consecutive cycles; no overlap, no gap between anodes.
- Frame period = 4*SCAN_DIV cycles; `frame` high one cycle per period, first at cycle 4*SCAN_DIV-1 after reset release.
- `load`-to-visible latency: 1 cycle if coincident with a frame boundary (display of `an1` next frame), otherwise until next frame boundary plus 1; worst case 4*SCAN_DIV cycles.
- Multiple `load`s within one frame: last one wins.

## Configuration
- `SEG7_ZERO_BLANK_EN` defined: leading-zero blanking. Digit k (k=3,2,1) is blanked (segments a..g all 1) when its nibble and all higher-index nibbles are 0; `digit0` never blanked; `dp` still follows bit4 on blanked digits; anode timing unchanged.
- Not defined: every digit always shows its hex pattern.

## Structure
- Shared package `seg7_pkg`: 7-bit segment pattern type, 16-entry hex-to-segment constant table, blank pattern constant, anode one-hot-low constants.
- One sub-module: `seg7_hex_decode` (combinational nibble + blank → a..g).
- Prescaler, index, buffers and output registers in the top of this block.

## Test plan
- SCAN_DIV=4, assert `reset` mid-scan → all outputs 1 within same timestep, `frame`=0; release → `an1`=0, a..g=0000001 one cycle later.
- Load digits 1,2,3,4 (bit4=0) → after next `frame`, an1..an4 show 1001111, 0010010, 0000110, 1001100, each for exactly 4 cycles.
- Load 5'b11111 to `digit2` mid-frame → old value shown until frame boundary; next frame `an3` shows F (0111000), `dp`=0.
- Two `load`s in one frame (0xA then 0x5 on digit0) → only 5 (0100100) ever appears on `an1`.
- `load` on the frame-boundary cycle with 8888 → `an1` shows 0000000 on the very next scan slot.
- With `SEG7_ZERO_BLANK_EN`, load 0,0,7,0 (digit0..3) → `an4` blank, `an3`=0001111, `an2`/`an1` show 0; without macro `an4` shows 0000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constant tables for the seven-segment scan driver.
// Segment patterns are active-low and ordered {a,b,c,d,e,f,g} from MSB to LSB.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;  // bit0 = an1 ... bit3 = an4

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t HEX_SEG [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam an_t AN_OFF = '1;
    localparam an_t AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Digit load port and multiplexed display pins of the seven-segment scan driver.
interface seg7_scan_mux_if;

    logic       load;
    logic [4:0] digit0, digit1, digit2, digit3;
    logic       a, b, c, d, e, f, g, dp;
    logic       an1, an2, an3, an4;
    logic       frame;

    modport master (
        output load, digit0, digit1, digit2, digit3,
        input  a, b, c, d, e, f, g, dp, an1, an2, an3, an4, frame
    );

    modport slave (
        input  load, digit0, digit1, digit2, digit3,
        output a, b, c, d, e, f, g, dp, an1, an2, an3, an4, frame
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g pattern, with forced blanking.
import seg7_pkg::*;

module seg7_hex_decode (
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit double-buffered seven-segment scan multiplexer.
// Define SEG7_ZERO_BLANK_EN to blank leading zero digits (digit0 is never blanked).
import seg7_pkg::*;

module seg7_scan_mux #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic            clk,
    input  logic            reset,
    seg7_scan_mux_if.slave  bus
);

    localparam logic [15:0] PTERM = 16'(SCAN_DIV - 1);

    logic [15:0] pcnt;
    logic [1:0]  idx;
    logic [4:0]  din    [4];
    logic [4:0]  shadow [4];
    logic [4:0]  active [4];
    logic        tick, boundary, blank;
    seg_t        seg, seg_q;
    an_t         an_q;
    logic        dp_q;

    assign tick     = (pcnt == PTERM);
    assign boundary = tick && (idx == 2'd3);

    always_comb begin
        din[0] = bus.digit0;
        din[1] = bus.digit1;
        din[2] = bus.digit2;
        din[3] = bus.digit3;
    end

`ifdef SEG7_ZERO_BLANK_EN
    // Blank when this digit and every higher-index digit hold a zero nibble.
    always_comb begin
        blank = (idx != 2'd0);
        for (int unsigned j = 0; j < 4; j++) begin
            if (j >= 32'(idx) && active[j][3:0] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seg7_hex_decode u_dec (
        .nibble (active[idx][3:0]),
        .blank  (blank),
        .seg    (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt   <= '0;
            idx    <= '0;
            shadow <= '{default: '0};
            active <= '{default: '0};
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
            dp_q   <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + 16'd1;
            if (tick) idx <= idx + 2'd1;
            if (bus.load) shadow <= din;
            // A load on the boundary cycle bypasses the shadow straight into the active set.
            if (boundary) active <= bus.load ? din : shadow;
            an_q  <= AN_SEL[idx];
            seg_q <= seg;
            dp_q  <= ~active[idx][4];
        end
    end

    assign bus.a     = seg_q[6];
    assign bus.b     = seg_q[5];
    assign bus.c     = seg_q[4];
    assign bus.d     = seg_q[3];
    assign bus.e     = seg_q[2];
    assign bus.f     = seg_q[1];
    assign bus.g     = seg_q[0];
    assign bus.dp    = dp_q;
    assign bus.an1   = an_q[0];
    assign bus.an2   = an_q[1];
    assign bus.an3   = an_q[2];
    assign bus.an4   = an_q[3];
    assign bus.frame = boundary;

endmodule
